// File: rtl/bcd_tick_counter_if.sv
// bcd_tick_counter_if: control and count bundle between the BCD tick counter
// and its neighbours. The optional seg bundle member exists only when
// BCD_TICK_SEG7_EN is defined.
interface bcd_tick_counter_if #(
   parameter int DIGITS = 2
) ();
   logic                  tick_in;
   logic                  en;
   logic                  up;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic [4*DIGITS-1:0]   bcd;
   logic                  tc;
`ifdef BCD_TICK_SEG7_EN
   logic [7*DIGITS-1:0]   seg;
`endif

   // Driver side: produces tick/control, observes the count.
   modport master (
      output tick_in,
      output en,
      output up,
      output load,
      output load_val,
`ifdef BCD_TICK_SEG7_EN
      input  seg,
`endif
      input  bcd,
      input  tc
   );

   // Counter side.
   modport slave (
      input  tick_in,
      input  en,
      input  up,
      input  load,
      input  load_val,
`ifdef BCD_TICK_SEG7_EN
      output seg,
`endif
      output bcd,
      output tc
   );
endinterface

// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: multi-digit BCD up/down counter advanced by rising edges
// of a slow divided square wave. Load has priority over counting; tc pulses
// for one cycle when the count wraps in either direction.
// Optional feature macro: BCD_TICK_SEG7_EN adds a registered, active-low
// seven-segment decode (g..a per digit) that trails bcd by one cycle.
module bcd_tick_counter #(
   parameter int DIGITS = 2
) (
   input  logic              clk,
   input  logic              rst,      // asynchronous, active-low
   bcd_tick_counter_if.slave bus
);

   localparam int W = 4 * DIGITS;

   logic          tick_s1_q, tick_s1_d;
   logic          tick_s2_q, tick_s2_d;
   logic          step;
   logic [W-1:0]  bcd_q, bcd_d;
   logic          tc_q, tc_d;

   logic [W-1:0]  inc_val;
   logic [W-1:0]  dec_val;
   logic [W-1:0]  load_clean;
   logic [DIGITS:0] carry;
   logic [DIGITS:0] borrow;

   assign step      = tick_s1_q & ~tick_s2_q;
   assign carry[0]  = 1'b1;
   assign borrow[0] = 1'b1;

   // Per-digit ripple: a digit changes only when every lower digit wrapped.
   // carry[DIGITS] / borrow[DIGITS] therefore flag the all-9 / all-0 wrap.
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         logic [3:0] dig;
         logic [3:0] ld;
         assign dig = bcd_q[4*gi +: 4];
         assign ld  = bus.load_val[4*gi +: 4];

         assign inc_val[4*gi +: 4] = !carry[gi]    ? dig :
                                     (dig == 4'd9) ? 4'd0 : dig + 4'd1;
         assign carry[gi+1]        = carry[gi] & (dig == 4'd9);

         assign dec_val[4*gi +: 4] = !borrow[gi]   ? dig :
                                     (dig == 4'd0) ? 4'd9 : dig - 4'd1;
         assign borrow[gi+1]       = borrow[gi] & (dig == 4'd0);

         // Non-decimal nibbles are forced to 0 so bcd never holds >9.
         assign load_clean[4*gi +: 4] = (ld > 4'd9) ? 4'd0 : ld;
      end
   endgenerate

   // Next-state: edge-detect shift, then load > enabled step > hold.
   always_comb begin
      tick_s1_d = bus.tick_in;
      tick_s2_d = tick_s1_q;
      bcd_d     = bcd_q;
      tc_d      = 1'b0;
      if (bus.load) begin
         bcd_d = load_clean;
      end else if (step && bus.en) begin
         if (bus.up) begin
            bcd_d = inc_val;
            tc_d  = carry[DIGITS];
         end else begin
            bcd_d = dec_val;
            tc_d  = borrow[DIGITS];
         end
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_s1_q <= 1'b0;
         tick_s2_q <= 1'b0;
         bcd_q     <= '0;
         tc_q      <= 1'b0;
      end else begin
         tick_s1_q <= tick_s1_d;
         tick_s2_q <= tick_s2_d;
         bcd_q     <= bcd_d;
         tc_q      <= tc_d;
      end
   end

   assign bus.bcd = bcd_q;
   assign bus.tc  = tc_q;

`ifdef BCD_TICK_SEG7_EN
   logic [7*DIGITS-1:0] seg_q, seg_d;

   // Active-low g..a pattern for one decimal digit.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Decode the registered count, so seg trails bcd by one cycle.
   always_comb begin
      seg_d = '1;
      for (int i = 0; i < DIGITS; i++) begin
         seg_d[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
      end
   end

   // Segment register; blank after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg_q <= '1;
      end else begin
         seg_q <= seg_d;
      end
   end

   assign bus.seg = seg_q;
`endif

endmodule

// File: tb/tb_bcd_tick_counter.sv
// tb_bcd_tick_counter: directed and randomized stimulus for bcd_tick_counter
// checked every cycle against an integer-arithmetic reference model.
module tb_bcd_tick_counter;

   localparam int D = 2;
   localparam int W = 4 * D;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   bcd_tick_counter_if #(.DIGITS(D)) bus ();

   bcd_tick_counter #(.DIGITS(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (integer count) ----------------
   int            m_count;
   logic          m_tc;
   logic          m_s1, m_s2;
   logic [7*D-1:0] m_seg;
   int            modv;

   function automatic int pow10(input int n);
      int r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int t = v;
      r = '0;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int clean_val(input logic [W-1:0] lv);
      int r = 0;
      int nib;
      for (int i = 0; i < D; i++) begin
         nib = int'(lv[4*i +: 4]);
         if (nib > 9) nib = 0;
         r = r + nib * pow10(i);
      end
      return r;
   endfunction

   function automatic logic [6:0] seg_pat(input int d);
      logic [6:0] tbl [10];
      tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      return tbl[d];
   endfunction

   function automatic logic [7*D-1:0] seg_of(input int v);
      logic [7*D-1:0] r;
      int t = v;
      for (int i = 0; i < D; i++) begin
         r[7*i +: 7] = seg_pat(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_count = 0;
      m_tc    = 1'b0;
      m_s1    = 1'b0;
      m_s2    = 1'b0;
      m_seg   = '1;
   endtask

   // One clock: model advances with the inputs present at the edge, then compare.
   task automatic cycle();
      logic step;
      int   old;
      @(posedge clk);
      old  = m_count;
      step = m_s1 && !m_s2;
      if (bus.load) begin
         m_count = clean_val(bus.load_val);
         m_tc    = 1'b0;
      end else if (step && bus.en) begin
         if (bus.up) begin
            m_tc    = (m_count == modv - 1);
            m_count = (m_count + 1) % modv;
         end else begin
            m_tc    = (m_count == 0);
            m_count = (m_count + modv - 1) % modv;
         end
      end else begin
         m_tc = 1'b0;
      end
      m_s2  = m_s1;
      m_s1  = bus.tick_in;
      m_seg = seg_of(old);
      #1;
      check("bcd", 32'(bus.bcd), 32'(to_bcd(m_count)));
      check("tc", 32'(bus.tc), 32'(m_tc));
`ifdef BCD_TICK_SEG7_EN
      check("seg", 32'(bus.seg), 32'(m_seg));
`endif
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // One full tick_in period: rising edge, hold high, fall, hold low.
   task automatic pulse_edge();
      bus.tick_in = 1'b1;
      cycles(2);
      bus.tick_in = 1'b0;
      cycles(2);
   endtask

   task automatic do_load(input logic [W-1:0] v);
      bus.load     = 1'b1;
      bus.load_val = v;
      cycle();
      bus.load     = 1'b0;
   endtask

   // Assert reset between edges and confirm the clear is immediate.
   task automatic async_reset(input int hold_cycles);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("rst_async_bcd", 32'(bus.bcd), 32'(0));
      check("rst_async_tc", 32'(bus.tc), 32'(0));
      for (int i = 0; i < hold_cycles; i++) begin
         bus.tick_in = ~bus.tick_in;
         @(posedge clk);
         #1;
         check("rst_hold_bcd", 32'(bus.bcd), 32'(0));
         check("rst_hold_tc", 32'(bus.tc), 32'(0));
`ifdef BCD_TICK_SEG7_EN
         check("rst_hold_seg", 32'(bus.seg), 32'({7*D{1'b1}}));
`endif
      end
      rst = 1'b1;
   endtask

   initial begin
      int hold;
      modv         = pow10(D);
      bus.tick_in  = 1'b0;
      bus.en       = 1'b1;
      bus.up       = 1'b1;
      bus.load     = 1'b0;
      bus.load_val = '0;
      model_reset();

      // Reset with tick_in toggling, then release with tick_in low.
      repeat (2) @(posedge clk);
      #1;
      async_reset(6);
      bus.tick_in = 1'b0;
      cycles(3);
      bus.tick_in = 1'b1;
      cycle();
      check("first_edge_lat1", 32'(bus.bcd), 32'h00);
      cycle();
      check("first_edge_lat2", 32'(bus.bcd), 32'h01);
      bus.tick_in = 1'b0;
      cycles(2);

      // Up wrap 98 -> 99 -> 00 with a single tc pulse.
      do_load(8'h98);
      bus.up = 1'b1;
      pulse_edge();
      check("up_99", 32'(bus.bcd), 32'h99);
      bus.tick_in = 1'b1;
      cycle();
      cycle();
      check("up_wrap_bcd", 32'(bus.bcd), 32'h00);
      check("up_wrap_tc", 32'(bus.tc), 32'd1);
      cycle();
      check("up_wrap_tc_drop", 32'(bus.tc), 32'd0);
      bus.tick_in = 1'b0;
      cycles(2);

      // Down wrap 01 -> 00 -> 99 -> 98.
      do_load(8'h01);
      bus.up = 1'b0;
      pulse_edge();
      check("dn_00", 32'(bus.bcd), 32'h00);
      pulse_edge();
      check("dn_99", 32'(bus.bcd), 32'h99);
      pulse_edge();
      check("dn_98", 32'(bus.bcd), 32'h98);

      // Enable gating: discarded edge, then exactly one count.
      bus.en = 1'b0;
      pulse_edge();
      check("en_gate", 32'(bus.bcd), 32'h98);
      bus.en = 1'b1;
      pulse_edge();
      check("en_resume", 32'(bus.bcd), 32'h97);

      // Load coincident with a step: invalid low nibble -> 0, step dropped.
      bus.up      = 1'b1;
      bus.tick_in = 1'b1;
      cycle();
      bus.load     = 1'b1;
      bus.load_val = 8'h4F;
      cycle();
      bus.load     = 1'b0;
      check("load_prio_bcd", 32'(bus.bcd), 32'h40);
      check("load_prio_tc", 32'(bus.tc), 32'd0);
      cycles(2);
      bus.tick_in = 1'b0;
      cycles(2);
      check("load_no_step", 32'(bus.bcd), 32'h40);

      // Load 99 then wrap-free check that tc never fires on load.
      do_load(8'h99);
      check("load_tc", 32'(bus.tc), 32'd0);

`ifdef BCD_TICK_SEG7_EN
      do_load(8'h08);
      check("seg_lag", 32'(bus.seg), 32'(seg_of(99)));
      cycle();
      check("seg_08", 32'(bus.seg), 32'(14'b1000000_0000000));
`endif

      // Randomized phase with a mid-run reset released while tick_in is high.
      for (int iter = 0; iter < 160; iter++) begin
         if (iter == 80) begin
            async_reset(3);
            bus.tick_in = 1'b1;
            bus.load    = 1'b0;
         end else begin
            bus.tick_in = ~bus.tick_in;
         end
         hold = int'($urandom_range(2, 4));
         for (int k = 0; k < hold; k++) begin
            bus.en       = ($urandom_range(0, 9) < 8);
            bus.up       = 1'($urandom_range(0, 1));
            bus.load     = ($urandom_range(0, 19) == 0);
            bus.load_val = W'($urandom);
            cycle();
         end
         bus.load = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
